// File: rtl/la_dmux5_arb.sv
// la_dmux5_arb: round-robin arbiter driving a registered one-hot 5:1 mux select.
// Optional grant statistics counter enabled by `define LA_DMUX5_ARB_STATS_EN.
module la_dmux5_arb #(
  parameter string PROP     = "DEFAULT",
  parameter int    MAXBEATS = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] req,
  input  logic       lock,
  input  logic       ready,
  output logic [4:0] sel,
  output logic       valid,
  output logic [2:0] owner
`ifdef LA_DMUX5_ARB_STATS_EN
  ,
  output logic [15:0] grants
`endif
);

  // PROP only tunes implementation; it carries no logic.
  if (PROP == "") begin : g_prop_empty
  end

  localparam bit         LP_CAP  = (MAXBEATS > 0);
  localparam logic [7:0] LP_LAST = LP_CAP ? 8'(MAXBEATS - 1) : 8'd0;

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [4:0] r_sel;
  logic [4:0] w_sel_nxt;
  logic [2:0] r_owner;
  logic [2:0] w_owner_nxt;
  logic [2:0] r_ptr;
  logic [2:0] w_ptr_nxt;
  logic [7:0] r_beat;
  logic [7:0] w_beat_nxt;
  logic       w_grant_evt;

  logic       w_own_req;
  logic       w_xfer;
  logic       w_last;
  logic       w_rel;
  logic [2:0] w_after;
  logic [3:0] w_pick_idle;
  logic [3:0] w_pick_rel;

  // First set bit of v scanning s, s+1, ... mod 5; returns {found, index}.
  function automatic logic [3:0] f_pick(
    input logic [4:0] v,
    input logic [2:0] s
  );
    logic [3:0] r;
    int         t;
    r = 4'b0;
    for (int k = 4; k >= 0; k--) begin
      t = int'(s) + k;
      if (t >= 5) t = t - 5;
      if (v[t]) r = {1'b1, 3'(t)};
    end
    return r;
  endfunction

  function automatic logic [4:0] f_onehot(input logic [2:0] i);
    return 5'd1 << i;
  endfunction

  assign w_own_req   = |(r_sel & req);
  assign w_xfer      = w_own_req & ready;
  assign w_last      = LP_CAP && (r_beat == LP_LAST);
  assign w_rel       = (w_xfer & ~lock) | (w_xfer & w_last) | ~w_own_req;
  assign w_after     = (r_owner == 3'd4) ? 3'd0 : r_owner + 3'd1;
  assign w_pick_idle = f_pick(req, r_ptr);
  assign w_pick_rel  = f_pick(req & ~r_sel, w_after);

  // Next-state, select, pointer and beat counter selection.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_beat_nxt  = r_beat;
    w_grant_evt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_pick_idle[3]) begin
          w_state_nxt = S_GRANT;
          w_sel_nxt   = f_onehot(w_pick_idle[2:0]);
          w_owner_nxt = w_pick_idle[2:0];
          w_beat_nxt  = 8'd0;
          w_grant_evt = 1'b1;
        end
      end
      S_GRANT: begin
        if (w_rel) begin
          w_ptr_nxt  = w_after;
          w_beat_nxt = 8'd0;
          if (w_pick_rel[3]) begin
            w_sel_nxt   = f_onehot(w_pick_rel[2:0]);
            w_owner_nxt = w_pick_rel[2:0];
            w_grant_evt = 1'b1;
          end else if (w_own_req) begin
            w_grant_evt = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_sel_nxt   = 5'b0;
            w_owner_nxt = 3'd0;
          end
        end else if (w_xfer && r_beat != 8'hFF) begin
          w_beat_nxt = r_beat + 8'd1;
        end
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sel   <= 5'b0;
      r_owner <= 3'd0;
      r_ptr   <= 3'd0;
      r_beat  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

`ifdef LA_DMUX5_ARB_STATS_EN
  logic [15:0] r_grants;

  // Saturating count of grant events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grants <= 16'd0;
    end else if (w_grant_evt && r_grants != 16'hFFFF) begin
      r_grants <= r_grants + 16'd1;
    end
  end

  assign grants = r_grants;
`endif

  assign sel   = r_sel;
  assign owner = r_owner;
  assign valid = w_own_req;

endmodule

// File: tb/tb_la_dmux5_arb.sv
// tb_la_dmux5_arb: checks two arbiter builds (MAXBEATS 0 and 3)
// against a queue-free behavioural model of the grant rules.
module tb_la_dmux5_arb;

  logic       clk;
  logic       reset;
  logic [4:0] req;
  logic       lock;
  logic       ready;
  logic [4:0] sel0, sel3;
  logic       val0, val3;
  logic [2:0] own0, own3;
`ifdef LA_DMUX5_ARB_STATS_EN
  logic [15:0] gr0, gr3;
`endif

  int total = 0;
  int bad   = 0;

  int mown[2];
  int mptr[2];
  int mbeat[2];
  int mgr[2];
  int mmax[2];

  la_dmux5_arb #(.PROP("DEFAULT"), .MAXBEATS(0)) u0 (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .ready(ready),
    .sel(sel0), .valid(val0), .owner(own0)
`ifdef LA_DMUX5_ARB_STATS_EN
    , .grants(gr0)
`endif
  );

  la_dmux5_arb #(.PROP("DEFAULT"), .MAXBEATS(3)) u3 (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .ready(ready),
    .sel(sel3), .valid(val3), .owner(own3)
`ifdef LA_DMUX5_ARB_STATS_EN
    , .grants(gr3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [4:0] v, input int s);
    for (int k = 0; k < 5; k++) begin
      if (v[(s + k) % 5]) return (s + k) % 5;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mown[m] = -1; mptr[m] = 0; mbeat[m] = 0; mgr[m] = 0;
    end
  endtask

  task automatic model_grant(input int m, input int who);
    mown[m]  = who;
    mbeat[m] = 0;
    if (who >= 0 && mgr[m] < 65535) mgr[m]++;
  endtask

  task automatic model_step();
    int  i, n;
    bit  xfer, rel;
    logic [4:0] oth;
    for (int m = 0; m < 2; m++) begin
      if (mown[m] < 0) begin
        if (req != 0) model_grant(m, pick(req, mptr[m]));
      end else begin
        i    = mown[m];
        xfer = req[i] && ready;
        rel  = (xfer && !lock) || !req[i] ||
               (xfer && mmax[m] != 0 && mbeat[m] == mmax[m] - 1);
        if (rel) begin
          mptr[m] = (i + 1) % 5;
          oth     = req;
          oth[i]  = 1'b0;
          n       = pick(oth, mptr[m]);
          if (n < 0 && req[i]) n = i;
          model_grant(m, n);
        end else if (xfer && mbeat[m] < 255) begin
          mbeat[m]++;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [4:0] es;
    logic [2:0] eo;
    logic       ev;
    for (int m = 0; m < 2; m++) begin
      es = (mown[m] < 0) ? 5'b0 : 5'(5'd1 << mown[m]);
      eo = (mown[m] < 0) ? 3'd0 : 3'(mown[m]);
      ev = (mown[m] >= 0) && req[mown[m]];
      chk($sformatf("sel_u%0d", m), 16'(m == 0 ? sel0 : sel3), 16'(es));
      chk($sformatf("owner_u%0d", m), 16'(m == 0 ? own0 : own3), 16'(eo));
      chk($sformatf("valid_u%0d", m), 16'(m == 0 ? val0 : val3), 16'(ev));
      chk($sformatf("onehot_u%0d", m),
          16'($countones(m == 0 ? sel0 : sel3) <= 1), 16'd1);
`ifdef LA_DMUX5_ARB_STATS_EN
      chk($sformatf("grants_u%0d", m), m == 0 ? gr0 : gr3, 16'(mgr[m]));
`endif
    end
  endtask

  task automatic cyc(input logic [4:0] r, input logic l, input logic rd);
    req = r; lock = l; ready = rd;
    #2;
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = 5'b0; lock = 1'b0; ready = 1'b0;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    mmax[0] = 0;
    mmax[1] = 3;
    reset = 1'b1; req = 5'b0; lock = 1'b0; ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Two pending requests from reset: 2 then 4, then idle.
    cyc(5'b10100, 1'b0, 1'b1);
    chk("tp1_sel2", 16'(sel0), 16'h04);
    chk("tp1_own2", 16'(own0), 16'd2);
    cyc(5'b10100, 1'b0, 1'b1);
    chk("tp1_sel4", 16'(sel0), 16'h10);
    chk("tp1_own4", 16'(own0), 16'd4);
    cyc(5'b10000, 1'b0, 1'b1);
    cyc(5'b00000, 1'b0, 1'b1);
    chk("tp1_idle_sel", 16'(sel0), 16'h00);
    chk("tp1_idle_valid", 16'(val0), 16'd0);

    // All requesting: rotating single-beat grants, no bubbles.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cyc(5'b11111, 1'b0, 1'b1);
      chk("rr_order", 16'(sel0), 16'(5'd1 << (k % 5)));
    end

    // Locked bursts: cap of 3 on u3, unlimited on u0.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      cyc(5'b00011, 1'b1, 1'b1);
      chk("cap_sel_u3", 16'(sel3),
          16'(((k >= 3) && (k <= 5)) ? 5'b00010 : 5'b00001));
      chk("nocap_sel_u0", 16'(sel0), 16'h01);
    end

    // Owner 1 drops mid-lock with no transfer; handoff straight to 3.
    do_reset();
    cyc(5'b00010, 1'b0, 1'b0);
    chk("drop_own1", 16'(sel0), 16'h02);
    cyc(5'b01010, 1'b1, 1'b0);
    chk("drop_hold", 16'(sel0), 16'h02);
    cyc(5'b01000, 1'b1, 1'b0);
    chk("drop_to3", 16'(sel0), 16'h08);
    cyc(5'b01000, 1'b1, 1'b1);
    chk("burst3", 16'(sel0), 16'h08);

    // Asynchronous reset mid-burst, then pointer back to 0.
    req = 5'b01000; lock = 1'b1; ready = 1'b1;
    reset = 1'b1;
    #1;
    chk("async_sel_u0", 16'(sel0), 16'h00);
    chk("async_sel_u3", 16'(sel3), 16'h00);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(5'b11111, 1'b0, 1'b1);
    chk("post_rst_first", 16'(sel0), 16'h01);

    // Randomised traffic against the model.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      cyc(5'($urandom), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 3) != 0));
    end

`ifdef LA_DMUX5_ARB_STATS_EN
    // Grant counter saturation with a lone requester.
    do_reset();
    for (int k = 0; k < 70000; k++) begin
      cyc(5'b00001, 1'b0, 1'b1);
    end
    chk("grants_sat_u0", gr0, 16'hFFFF);
    cyc(5'b00001, 1'b0, 1'b1);
    chk("grants_hold_u0", gr0, 16'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
